serial_addsub8: RTL and testbench

Bit-serial adder/subtractor for the 8-bit ALU datapath. It reuses a single full-adder cell plus a carry flop over WIDTH cycles, LSB first. A start/done handshake frames each operation. It is the sequential inverse-direction companion to the parallel adder path: it provides subtraction (A − B) as well as addition, and it produces ALU flags.

---
 rtl/serial_addsub8.sv | 112 +++++++++++
 tb/tb_serial_addsub8.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub8.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop iterated LSB first over WIDTH cycles.
// Optional carry-in port (ADC/SBC semantics) is enabled by defining SERIAL_ADDSUB_CIN_EN.
module serial_addsub8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDSUB_CIN_EN
    input  logic             cin,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sign_a;
    logic             sign_b;

    logic             init_carry;
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] shifted;

    always_comb begin
`ifdef SERIAL_ADDSUB_CIN_EN
        init_carry = cin;
`else
        init_carry = sub;
`endif
        bit_sum   = sa[0] ^ sb[0] ^ carry;
        bit_carry = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        shifted   = {bit_sum, sr[WIDTH-1:1]};
    end

    // Subtraction is a + ~b + 1: b is inverted once at capture, the +1 comes from the initial carry.
    always_ff @(posedge clk) begin
        // NOTE: every register here is state, so all assignments are non-blocking; the
        // combinational terms above are computed in always_comb from current values only.
        if (!rst_n) begin
            state    <= S_IDLE;
            sa       <= '0;
            sb       <= '0;
            sr       <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sa     <= a;
                        sb     <= sub ? ~b : b;
                        sr     <= '0;
                        cnt    <= '0;
                        carry  <= init_carry;
                        sign_a <= a[WIDTH-1];
                        sign_b <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        state  <= S_RUN;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    carry <= bit_carry;
                    sr    <= shifted;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        result   <= shifted;
                        cout     <= bit_carry;
                        overflow <= (sign_a == sign_b) && (bit_sum != sign_a);
                        zero     <= (shifted == '0);
                        state    <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state != S_RUN);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_serial_addsub8.sv
// Randomized scoreboard bench for serial_addsub8; expected results come from plain integer arithmetic.
// Define SERIAL_ADDSUB_CIN_EN for both files to exercise the carry-in port.
module tb_serial_addsub8;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [7:0]  res;
        logic        co;
        logic        ov;
        logic        z;
        logic [31:0] due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             ready, busy, done, cout, overflow, zero;
    logic [WIDTH-1:0] result;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] cyc = 0;
    exp_t        sb_q[$];
    logic [7:0]  last_res = 8'h00;

    serial_addsub8 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
`ifdef SERIAL_ADDSUB_CIN_EN
        .cin      (cin),
`endif
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: unsigned/signed integer arithmetic, carry-in folded in as +c (add) or -(1-c) (sub).
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic s, input logic c);
        exp_t e;
        int ux, uy, sx, sy, ci, u, sv;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ci = c ? 1 : 0;
        if (!s) begin
            u    = ux + uy + ci;
            sv   = sx + sy + ci;
            e.co = (u > 255);
        end else begin
            u    = ux - uy - (1 - ci);
            sv   = sx - sy - (1 - ci);
            e.co = (u >= 0);
        end
        e.res = 8'(u & 255);
        e.ov  = (sv > 127) || (sv < -128);
        e.z   = (e.res == 8'h00);
        e.due = '0;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 with no operation outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("cout", 32'(cout), 32'(e.co));
                check("overflow", 32'(overflow), 32'(e.ov));
                check("zero", 32'(zero), 32'(e.z));
                check("latency", cyc, e.due);
                last_res = e.res;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Called at a negedge with ready=1; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s, input logic c);
        exp_t e;
        logic eff_c;
`ifdef SERIAL_ADDSUB_CIN_EN
        eff_c = c;
`else
        eff_c = s;
`endif
        e     = model(x, y, s, eff_c);
        e.due = cyc + 1 + WIDTH;
        sb_q.push_back(e);
        a = x; b = y; sub = s; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("done_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_wait_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_cleared("reset");

        // Directed arithmetic corners
        issue(8'h05, 8'h03, 1'b0, 1'b0);
        check("busy_in_run", 32'(busy), 32'd1);
        check("ready_in_run", 32'(ready), 32'd0);
        wait_drain(); wait_ready();
        issue(8'hFF, 8'h01, 1'b0, 1'b0); wait_drain(); wait_ready();
        issue(8'h7F, 8'h01, 1'b0, 1'b0); wait_drain(); wait_ready();
        issue(8'h03, 8'h05, 1'b1, 1'b1); wait_drain(); wait_ready();
        issue(8'h80, 8'h01, 1'b1, 1'b1); wait_drain(); wait_ready();

        // Start during RUN is ignored; outputs hold the previous result meanwhile
        issue(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("held_result", 32'(result), 32'(last_res));
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("ready_in_done", 32'(ready), 32'd1);
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_drain(); wait_ready();

        // Reset in the middle of RUN aborts without a done pulse
        issue(8'h0F, 8'h01, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        check_cleared("midrun_reset");
        repeat (WIDTH + 2) @(negedge clk);
        issue(8'h21, 8'h12, 1'b0, 1'b0); wait_drain(); wait_ready();

`ifdef SERIAL_ADDSUB_CIN_EN
        issue(8'hFF, 8'h00, 1'b0, 1'b1); wait_drain(); wait_ready();
        issue(8'h05, 8'h03, 1'b1, 1'b0); wait_drain(); wait_ready();
`endif

        // Randomized traffic, mixing back-to-back issue with idle gaps
        for (int i = 0; i < 60; i++) begin
            logic [7:0] x, y;
            logic s, c;
            x = 8'($urandom);
            y = 8'($urandom);
            if ($urandom_range(0, 7) == 0) y = x;
            s = 1'($urandom);
            c = 1'($urandom);
            wait_ready();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                wait_ready();
            end
            issue(x, y, s, c);
        end
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
